// File: rtl/azadi_soc_ctrl_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : azadi_soc_ctrl_wb
// Brief   : Wishbone-slave core reset sequencer with PROG strap and UART baud.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module azadi_soc_ctrl_wb #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] DEF_CPB   = 16'd868,
  parameter logic [15:0] DEF_HOLD  = 16'd16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        boot_led_i,
  output logic        soc_rst_no,
  output logic [15:0] clks_per_bit_o,
  output logic        prog_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] c_OFF_CTRL   = 2'd0;
  localparam logic [1:0] c_OFF_CPB    = 2'd1;
  localparam logic [1:0] c_OFF_HOLD   = 2'd2;
  localparam logic [1:0] c_OFF_STATUS = 2'd3;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [1:0]  r_ctrl;
  logic        r_soft;
  logic [15:0] r_cpb_sh;
  logic [15:0] r_hold;
  logic [15:0] r_cpb_act;
  logic        r_irq;
  logic [15:0] r_cnt;
  logic        r_led_s1;
  logic        r_led_s2;
  state_t      r_state;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_irq_nxt;
  logic [15:0] w_hold_load;
  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  sel);
    logic [15:0] res;
    res[7:0]  = sel[0] ? new_v[7:0]  : old_v[7:0];
    res[15:8] = sel[1] ? new_v[15:8] : old_v[15:8];
    return res;
  endfunction

  // The ~ack term turns a held strobe into one ack every other cycle.
  assign w_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_off = wbs_adr_i[3:2];

  assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      c_OFF_CTRL:   w_rdata = {30'd0, r_ctrl};
      c_OFF_CPB:    w_rdata = {16'd0, r_cpb_sh};
      c_OFF_HOLD:   w_rdata = {16'd0, r_hold};
      c_OFF_STATUS: w_rdata = {r_cpb_act, 10'd0, r_state, 2'd0, r_led_s2, soc_rst_no};
      default:      w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= 32'd0;
      r_ctrl   <= 2'd0;
      r_soft   <= 1'b0;
      r_cpb_sh <= DEF_CPB;
      r_hold   <= DEF_HOLD;
      r_led_s1 <= 1'b0;
      r_led_s2 <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_soft   <= 1'b0;
      r_led_s1 <= boot_led_i;
      r_led_s2 <= r_led_s1;
      if (w_rd) begin
        r_dat <= w_rdata;
      end
      if (w_wr) begin
        case (w_off)
          c_OFF_CTRL: begin
            if (wbs_sel_i[0]) begin
              r_ctrl <= wbs_dat_i[1:0];
              r_soft <= wbs_dat_i[2];
            end
          end
          c_OFF_CPB:  r_cpb_sh <= merge16(r_cpb_sh, wbs_dat_i[15:0], wbs_sel_i[1:0]);
          c_OFF_HOLD: r_hold   <= merge16(r_hold, wbs_dat_i[15:0], wbs_sel_i[1:0]);
          default:    ;
        endcase
      end
    end
  end

  assign w_hold_load = (r_hold == 16'd0) ? 16'd1 : r_hold;

  // soc_en low dominates; in HOLD a soft reset beats the count expiring.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_irq_nxt   = 1'b0;
    if (!r_ctrl[0]) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = 16'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = w_hold_load;
        end
        ST_HOLD: begin
          if (r_soft) begin
            w_cnt_nxt = w_hold_load;
          end else if (r_cnt == 16'd1) begin
            w_state_nxt = ST_RUN;
            w_irq_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
        ST_RUN: begin
          if (r_soft) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = w_hold_load;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_OFF;
      r_cnt     <= 16'd0;
      r_irq     <= 1'b0;
      r_cpb_act <= DEF_CPB;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_irq_nxt;
      if (w_irq_nxt) begin
        r_cpb_act <= r_cpb_sh;
      end
    end
  end

  assign wbs_ack_o      = r_ack;
  assign wbs_dat_o      = r_dat;
  assign soc_rst_no     = (r_state == ST_RUN);
  assign clks_per_bit_o = r_cpb_act;
  assign prog_o         = r_ctrl[1];
  assign irq_o          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_azadi_soc_ctrl_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_azadi_soc_ctrl_wb
// Brief   : Self-checking bench for the SoC reset/config wishbone controller.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_azadi_soc_ctrl_wb;

  localparam logic [31:0] c_BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat_w = 32'd0;
  logic        ack;
  logic [31:0] dat_r;
  logic        boot_led = 1'b0;
  logic        soc_rst_n;
  logic [15:0] cpb;
  logic        prog;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  azadi_soc_ctrl_wb dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .boot_led_i(boot_led), .soc_rst_no(soc_rst_n), .clks_per_bit_o(cpb),
    .prog_o(prog), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [3:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  logic [1:0]  m_ctrl;
  logic [15:0] m_cpb;
  logic [15:0] m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called 1ns after a clock edge; returns 1ns after the ack edge.
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output bit acked);
    acked = 1'b0;
    rd    = 32'd0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd    = dat_r;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    bit          acked;
    wb_xfer(1'b1, c_BASE + {28'd0, off}, s, d, rd, acked);
    chk("wr_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] d);
    bit acked;
    wb_xfer(1'b0, c_BASE + {28'd0, off}, 4'hF, 32'd0, d, acked);
    chk("rd_ack", {31'd0, acked}, 32'd1);
  endtask

  // Cycles from the last ack edge until soc_rst_no rises, plus irq pulses seen.
  task automatic measure(output int rise_k, output int irq_n);
    rise_k = -1;
    irq_n  = 0;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      if (irq) irq_n++;
      if (soc_rst_n && rise_k < 0) rise_k = k;
      if (rise_k >= 0 && k >= rise_k + 3) break;
    end
  endtask

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [15:0] m;
    m = {{8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d[15:0] & m);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          acked;
    int          rise, nirq, hcnt, h;
    logic [31:0] rv;
    logic [3:0]  rs;
    logic [31:0] ra;

    tbl[0]  = '{1'b0, 4'h4, 4'hF, 32'h0,         32'd868};
    tbl[1]  = '{1'b0, 4'h8, 4'hF, 32'h0,         32'd16};
    tbl[2]  = '{1'b0, 4'hC, 4'hF, 32'h0,         32'h0364_0000};
    tbl[3]  = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 4'h8, 4'hF, 32'hFFFF_0020, 32'h0};
    tbl[5]  = '{1'b0, 4'h8, 4'hF, 32'h0,         32'h20};
    tbl[6]  = '{1'b1, 4'h8, 4'h2, 32'h0000_AB00, 32'h0};
    tbl[7]  = '{1'b0, 4'h8, 4'hF, 32'h0,         32'hAB20};
    tbl[8]  = '{1'b1, 4'h0, 4'hE, 32'h0000_0003, 32'h0};
    tbl[9]  = '{1'b0, 4'h0, 4'hF, 32'h0,         32'h0};
    tbl[10] = '{1'b1, 4'hC, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b0, 4'hC, 4'hF, 32'h0,         32'h0364_0000};
    tbl[12] = '{1'b1, 4'h8, 4'hF, 32'd16,        32'h0};
    tbl[13] = '{1'b0, 4'h8, 4'hF, 32'h0,         32'd16};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_soc_rst_no", {31'd0, soc_rst_n}, 32'd0);
    chk("rst_cpb", {16'd0, cpb}, 32'd868);
    chk("rst_prog_irq_ack", {29'd0, prog, irq, ack}, 32'd0);
    chk("rst_dat", dat_r, 32'd0);
    rst_ni = 1'b1;

    // Register map and byte-select behaviour while the core is off.
    foreach (tbl[i]) begin
      if (tbl[i].we) begin
        wr(tbl[i].off, tbl[i].sel, tbl[i].dat);
      end else begin
        rd_reg(tbl[i].off, d);
        chk($sformatf("tbl%0d", i), d, tbl[i].exp);
      end
    end
    @(posedge clk); #1;
    chk("ack_width", {31'd0, ack}, 32'd0);

    // Held strobe: ack on alternating cycles.
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = c_BASE + 32'h4; sel = 4'hF;
    hcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack) hcnt++;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("held_stb_acks", hcnt, 32'd3);
    @(posedge clk); #1;

    // Enable with default hold window.
    boot_led = 1'b1;
    wr(4'h0, 4'hF, 32'd1);
    measure(rise, nirq);
    chk("en_rise_cycles", rise, 32'd17);
    chk("en_irq_count", nirq, 32'd1);
    rd_reg(4'hC, d);
    chk("status_run", d, 32'h0364_0023);

    // Shadowed baud update and soft reset.
    wr(4'h4, 4'h1, 32'h1234);
    rd_reg(4'h4, d);
    chk("cpb_shadow", d, 32'h0334);
    chk("cpb_active_kept", {16'd0, cpb}, 32'd868);
    wr(4'h0, 4'hF, 32'd5);
    measure(rise, nirq);
    chk("soft_rise_cycles", rise, 32'd17);
    chk("soft_cpb_applied", {16'd0, cpb}, 32'h0334);

    // HOLD=0 acts as one cycle.
    wr(4'h0, 4'hF, 32'd0);
    wr(4'h8, 4'hF, 32'd0);
    wr(4'h0, 4'hF, 32'd1);
    measure(rise, nirq);
    chk("hold0_rise_cycles", rise, 32'd2);

    // Soft reset landing on the expiring hold cycle restarts the window.
    wr(4'h0, 4'hF, 32'd0);
    wr(4'h8, 4'hF, 32'd2);
    wr(4'h0, 4'hF, 32'd1);
    wr(4'h0, 4'hF, 32'd5);
    measure(rise, nirq);
    chk("collide_rise_cycles", rise, 32'd3);
    chk("collide_irq_count", nirq, 32'd1);

    // Disable from RUN, then foreign addresses.
    wr(4'h0, 4'hF, 32'd0);
    chk("dis_still_run", {31'd0, soc_rst_n}, 32'd1);
    @(posedge clk); #1;
    chk("dis_off", {31'd0, soc_rst_n}, 32'd0);
    wb_xfer(1'b1, 32'h3000_0014, 4'hF, 32'hDEAD, d, acked);
    chk("nomatch_ack_a", {31'd0, acked}, 32'd0);
    wb_xfer(1'b1, 32'h2000_0004, 4'hF, 32'hBEEF, d, acked);
    chk("nomatch_ack_b", {31'd0, acked}, 32'd0);
    rd_reg(4'h4, d);
    chk("nomatch_cpb", d, 32'h0334);

    // Reset mid-RUN.
    wr(4'h0, 4'hF, 32'd3);
    measure(rise, nirq);
    chk("prog_run_rise", rise, 32'd3);
    chk("prog_on", {31'd0, prog}, 32'd1);
    rd_reg(4'h8, d);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("midrst_soc_rst_no", {31'd0, soc_rst_n}, 32'd0);
    chk("midrst_cpb", {16'd0, cpb}, 32'd868);
    chk("midrst_prog_irq_ack", {29'd0, prog, irq, ack}, 32'd0);
    chk("midrst_dat", dat_r, 32'd0);
    rd_reg(4'h4, d);
    chk("midrst_cpb_reg", d, 32'd868);

    // Randomized register traffic against a transaction-level model.
    m_ctrl = 2'd0; m_cpb = 16'd868; m_hold = 16'd16;
    for (int n = 0; n < 40; n++) begin
      rv = $urandom;
      rs = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: begin
          wr(4'h0, rs, rv);
          if (rs[0]) m_ctrl = rv[1:0];
          chk("rnd_prog", {31'd0, prog}, {31'd0, m_ctrl[1]});
        end
        1: begin wr(4'h4, rs, rv); m_cpb  = mrg(m_cpb, rv, rs); end
        2: begin wr(4'h8, rs, rv); m_hold = mrg(m_hold, rv, rs); end
        3: begin
          rd_reg(4'h0, d); chk("rnd_ctrl", d, {30'd0, m_ctrl});
          rd_reg(4'h4, d); chk("rnd_cpb", d, {16'd0, m_cpb});
          rd_reg(4'h8, d); chk("rnd_hold", d, {16'd0, m_hold});
        end
        4: begin
          ra = $urandom;
          if (ra[31:4] == c_BASE[31:4]) ra[31] = ~ra[31];
          wb_xfer(1'b1, ra, 4'hF, rv, d, acked);
          chk("rnd_nomatch", {31'd0, acked}, 32'd0);
        end
        default: wr(4'hC, 4'hF, rv);
      endcase
    end

    // Randomized hold windows and baud values.
    for (int n = 0; n < 4; n++) begin
      h  = $urandom_range(0, 20);
      rv = $urandom;
      wr(4'h0, 4'hF, 32'd0);
      wr(4'h8, 4'hF, h);
      wr(4'h4, 4'hF, rv);
      wr(4'h0, 4'hF, 32'd1);
      measure(rise, nirq);
      chk("rnd_rise", rise, ((h < 1) ? 1 : h) + 1);
      chk("rnd_irq", nirq, 32'd1);
      chk("rnd_cpb_out", {16'd0, cpb}, {16'd0, rv[15:0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
